axi4lite_cmd_sequencer: RTL and testbench

//  Upstream command stage for the AXI4-Lite master/slave top. It buffers read/write commands in a FIFO.
//  It issues them one at a time on the top's start_write/start_read/addr/data controls, then waits for done.
//  It returns per-command responses (read data, error flag) through a response FIFO with valid/ready handshakes.

---
 rtl/axi4lite_pkg.sv | 29 ++
 rtl/axi4lite_sync_fifo.sv | 41 ++++
 rtl/axi4lite_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_axi4lite_cmd_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite command sequencer: access kinds, FSM states and
// the packed command/response records carried through the FIFOs.
package axi4lite_pkg;

    localparam int AXI_ADDR_W = 2;
    localparam int AXI_DATA_W = 8;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef struct packed {
        logic                  rw;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic                  rw;
        logic [AXI_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/axi4lite_sync_fifo.sv
// Single-clock FIFO with combinational head output. Push and pop in the same
// cycle are both honoured, including when full; callers never push when full without popping.
module axi4lite_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data only; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/axi4lite_cmd_sequencer.sv
// Queues host register commands, issues them one at a time to the AXI4-Lite top,
// and returns in-order responses (read data, timeout error) through a response FIFO.
module axi4lite_cmd_sequencer
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_W,
    parameter int DATA_WIDTH = AXI_DATA_W,
    parameter int CMD_DEPTH  = 4,
    parameter int RSP_DEPTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  start_write,
    output logic                  start_read,
    output logic [ADDR_WIDTH-1:0] axi_addr,
    output logic [DATA_WIDTH-1:0] axi_wdata,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic                  done,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_rw,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [CAW:0]   CMD_CAP = (CAW + 1)'(CMD_DEPTH);
    localparam logic [RAW+1:0] RSP_CAP = (RAW + 2)'(RSP_DEPTH);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic          cur_rw;
    logic [TW-1:0] wait_cnt;

    cmd_t          cmd_in;
    cmd_t          cmd_head;
    logic          cmd_push;
    logic          cmd_pop;
    logic          cmd_empty;
    logic [CAW:0]  cmd_count;

    rsp_t          rsp_in;
    rsp_t          rsp_head;
    logic          rsp_push;
    logic          rsp_pop;
    logic          rsp_empty;
    logic [RAW:0]  rsp_count;
    logic [RAW+1:0] rsp_committed;
    logic          in_flight;

    assign cmd_ready = (cmd_count != CMD_CAP);
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_in    = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};

    axi4lite_sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_push),
        .push_data (cmd_in),
        .pop       (cmd_pop),
        .pop_data  (cmd_head),
        .empty     (cmd_empty),
        .count     (cmd_count)
    );

    // A command only leaves the queue when its response is guaranteed a slot,
    // so the push at WAIT exit can never meet a full response FIFO.
    assign in_flight     = (state != IDLE);
    assign rsp_committed = {1'b0, rsp_count} + (RAW + 2)'(in_flight);
    assign cmd_pop       = (state == IDLE) && !cmd_empty && (rsp_committed < RSP_CAP);

    // done takes priority over the timeout when both land in the same cycle.
    assign rsp_push     = (state == WAIT) && (done || (wait_cnt == TO_LAST));
    assign rsp_in.rw    = cur_rw;
    assign rsp_in.rdata = (done && (cur_rw == RW_READ)) ? axi_rdata : '0;
    assign rsp_in.err   = !done;

    axi4lite_sync_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_push),
        .push_data (rsp_in),
        .pop       (rsp_pop),
        .pop_data  (rsp_head),
        .empty     (rsp_empty),
        .count     (rsp_count)
    );

    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_rw    = rsp_head.rw;
    assign rsp_rdata = rsp_head.rdata;
    assign rsp_err   = rsp_head.err;
    assign busy      = in_flight || (cmd_count != '0) || (rsp_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur_rw      <= RW_WRITE;
            wait_cnt    <= '0;
            start_write <= 1'b0;
            start_read  <= 1'b0;
            axi_addr    <= '0;
            axi_wdata   <= '0;
        end else begin
            start_write <= 1'b0;
            start_read  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_pop) begin
                        axi_addr    <= cmd_head.addr;
                        axi_wdata   <= cmd_head.wdata;
                        cur_rw      <= cmd_head.rw;
                        start_write <= (cmd_head.rw == RW_WRITE);
                        start_read  <= (cmd_head.rw == RW_READ);
                        wait_cnt    <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (rsp_push) state <= IDLE;
                    else          wait_cnt <= wait_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_cmd_sequencer.sv
// Directed bench for the command sequencer; a behavioural stand-in for the AXI4-Lite
// top answers start pulses with done after a programmable delay.
module tb_axi4lite_cmd_sequencer;
    localparam int TIMEOUT = 255;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       start_write;
    logic       start_read;
    logic [1:0] axi_addr;
    logic [7:0] axi_wdata;
    logic [7:0] axi_rdata;
    logic       done;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_rw;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Responder state: 0 = answer after resp_lat cycles, 1 = never answer.
    int         resp_mode = 0;
    int         resp_lat  = 3;
    int         force_req = 0;
    logic [7:0] model_mem [4];
    int         n_wr = 0;
    int         n_rd = 0;
    int         pulse_bad = 0;
    int         start_cyc = 0;
    int         done_cyc = 0;
    logic [1:0] last_addr = 2'd0;
    logic [7:0] last_wdata = 8'd0;

    axi4lite_cmd_sequencer #(
        .ADDR_WIDTH (2),
        .DATA_WIDTH (8),
        .CMD_DEPTH  (4),
        .RSP_DEPTH  (4),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .start_write (start_write),
        .start_read  (start_read),
        .axi_addr    (axi_addr),
        .axi_wdata   (axi_wdata),
        .axi_rdata   (axi_rdata),
        .done        (done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rw      (rsp_rw),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the AXI4-Lite top; acts exactly on the falling edge.
    initial begin : responder
        bit         pending;
        int         cd;
        logic [7:0] pend_rdata;
        bit         prev_start;
        int         force_seen;
        pending = 0; cd = 0; pend_rdata = 8'd0; prev_start = 0; force_seen = 0;
        done = 1'b0;
        axi_rdata = 8'd0;
        for (int i = 0; i < 4; i++) model_mem[i] = 8'd0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (pending) begin
                if (cd <= 1) begin
                    done = 1'b1; axi_rdata = pend_rdata; done_cyc = cyc; pending = 0;
                end else begin
                    cd--;
                end
            end
            if (force_req != force_seen) begin
                force_seen = force_req;
                done = 1'b1; axi_rdata = model_mem[last_addr]; done_cyc = cyc;
            end
            if (start_write || start_read) begin
                if (prev_start || (start_write && start_read)) pulse_bad++;
                if (start_write) begin
                    n_wr++; model_mem[axi_addr] = axi_wdata; pend_rdata = 8'hEE;
                end else begin
                    n_rd++; pend_rdata = model_mem[axi_addr];
                end
                last_addr = axi_addr; last_wdata = axi_wdata; start_cyc = cyc;
                if (resp_mode == 0) begin pending = 1; cd = resp_lat; end
            end
            prev_start = start_write || start_read;
            if (rst) pending = 0;
        end
    end

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic push_cmd(input logic rw, input logic [1:0] addr, input logic [7:0] wdata,
                            output int acc_cyc);
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready) break;
            tick;
        end
        if (!cmd_ready) begin
            total++;
            $display("FAIL push_wait: cmd_ready stayed %0b, required 1 within 300 cycles", cmd_ready);
        end
        cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = cmd_ready;
        tick;
        cmd_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic get_rsp(output logic rw, output logic [7:0] rdata, output logic err,
                           output int seen_cyc);
        for (int i = 0; i < 600; i++) begin
            if (rsp_valid) break;
            tick;
        end
        seen_cyc = cyc;
        if (!rsp_valid) begin
            total++;
            $display("FAIL rsp_wait: rsp_valid stayed %0b, required 1 within 600 cycles", rsp_valid);
            rw = 1'bx; rdata = 8'hxx; err = 1'bx;
            return;
        end
        rw = rsp_rw; rdata = rsp_rdata; err = rsp_err;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        total++; if (start_write !== 1'b0) $display("FAIL rst_start_write: got %b want 0", start_write); else passed++;
        total++; if (start_read !== 1'b0) $display("FAIL rst_start_read: got %b want 0", start_read); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (axi_addr !== 2'd0) $display("FAIL rst_axi_addr: got %h want 0", axi_addr); else passed++;
        total++; if (axi_wdata !== 8'd0) $display("FAIL rst_axi_wdata: got %h want 00", axi_wdata); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); else passed++;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_write_read;
        int c0, c1, seen, st, nw0, nr0;
        logic rw, err;
        logic [7:0] rd, la_wd;
        logic [1:0] la;
        resp_mode = 0; resp_lat = 3; nw0 = n_wr; nr0 = n_rd;
        push_cmd(1'b0, 2'd2, 8'h04, c0);
        push_cmd(1'b1, 2'd2, 8'h00, c1);
        st = start_cyc; la = last_addr; la_wd = last_wdata;
        // Accepted on edge N, popped on N+1, pulse seen by the top on N+2.
        total++; if (st !== c0 + 1) $display("FAIL wr_start_latency: got cycle %0d want %0d", st, c0 + 1); else passed++;
        total++; if (la !== 2'd2) $display("FAIL wr_axi_addr: got %h want 2", la); else passed++;
        total++; if (la_wd !== 8'h04) $display("FAIL wr_axi_wdata: got %h want 04", la_wd); else passed++;
        total++; if (n_wr - nw0 !== 1) $display("FAIL wr_pulses: got %0d want 1", n_wr - nw0); else passed++;
        get_rsp(rw, rd, err, seen);
        total++; if (seen !== done_cyc + 1) $display("FAIL wr_rsp_latency: got cycle %0d want %0d", seen, done_cyc + 1); else passed++;
        total++; if (rw !== 1'b0) $display("FAIL wr_rsp_rw: got %b want 0", rw); else passed++;
        total++; if (rd !== 8'h00) $display("FAIL wr_rsp_rdata: got %h want 00", rd); else passed++;
        total++; if (err !== 1'b0) $display("FAIL wr_rsp_err: got %b want 0", err); else passed++;
        get_rsp(rw, rd, err, seen);
        total++; if (rw !== 1'b1) $display("FAIL rd_rsp_rw: got %b want 1", rw); else passed++;
        total++; if (rd !== 8'h04) $display("FAIL rd_rsp_rdata: got %h want 04", rd); else passed++;
        total++; if (err !== 1'b0) $display("FAIL rd_rsp_err: got %b want 0", err); else passed++;
        total++; if (n_rd - nr0 !== 1) $display("FAIL rd_pulses: got %0d want 1", n_rd - nr0); else passed++;
        total++; if (pulse_bad !== 0) $display("FAIL pulse_shape: got %0d bad pulses want 0", pulse_bad); else passed++;
    endtask

    task automatic test_back_to_back;
        int accepted, base, seen;
        bit acc_now;
        logic rw, err;
        logic [7:0] rd, exp_rd;
        resp_mode = 0; resp_lat = 2; rsp_ready = 1'b0;
        base = n_wr + n_rd; accepted = 0;
        for (int k = 0; k < 60; k++) begin
            if (accepted < 10) begin
                cmd_valid = 1'b1; cmd_rw = (accepted >= 4);
                cmd_addr = accepted[1:0]; cmd_wdata = 8'(8'hA0 + accepted);
            end else begin
                cmd_valid = 1'b0;
            end
            acc_now = cmd_valid && cmd_ready;
            tick;
            if (acc_now) accepted++;
        end
        cmd_valid = 1'b0;
        total++; if (accepted !== 8) $display("FAIL bp_accepted: got %0d want 8", accepted); else passed++;
        total++; if (n_wr + n_rd - base !== 4) $display("FAIL bp_issued: got %0d want 4", n_wr + n_rd - base); else passed++;
        total++; if (cmd_ready !== 1'b0) $display("FAIL bp_cmd_ready: got %b want 0", cmd_ready); else passed++;
        total++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); else passed++;
        for (int i = 0; i < 8; i++) begin
            get_rsp(rw, rd, err, seen);
            exp_rd = (i >= 4) ? 8'(8'hA0 + i - 4) : 8'h00;
            total++; if (rw !== (i >= 4)) $display("FAIL bp_rsp%0d_rw: got %b want %b", i, rw, (i >= 4)); else passed++;
            total++; if (rd !== exp_rd) $display("FAIL bp_rsp%0d_rdata: got %h want %h", i, rd, exp_rd); else passed++;
            total++; if (err !== 1'b0) $display("FAIL bp_rsp%0d_err: got %b want 0", i, err); else passed++;
        end
        repeat (3) tick;
        total++; if (n_wr + n_rd - base !== 8) $display("FAIL bp_issued_total: got %0d want 8", n_wr + n_rd - base); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL bp_busy_end: got %b want 0", busy); else passed++;
    endtask

    task automatic test_timeout;
        int c, st, seen;
        logic rw, err;
        logic [7:0] rd;
        resp_mode = 1;
        push_cmd(1'b1, 2'd1, 8'h00, c);
        push_cmd(1'b0, 2'd3, 8'h5A, c);
        st = start_cyc;
        repeat (20) tick;
        resp_mode = 0; resp_lat = 3;
        get_rsp(rw, rd, err, seen);
        total++; if (seen - (st + 1) !== TIMEOUT) $display("FAIL to_latency: got %0d cycles want %0d", seen - (st + 1), TIMEOUT); else passed++;
        total++; if (rw !== 1'b1) $display("FAIL to_rsp_rw: got %b want 1", rw); else passed++;
        total++; if (rd !== 8'h00) $display("FAIL to_rsp_rdata: got %h want 00", rd); else passed++;
        total++; if (err !== 1'b1) $display("FAIL to_rsp_err: got %b want 1", err); else passed++;
        get_rsp(rw, rd, err, seen);
        total++; if (rw !== 1'b0) $display("FAIL to_next_rw: got %b want 0", rw); else passed++;
        total++; if (err !== 1'b0) $display("FAIL to_next_err: got %b want 0", err); else passed++;
        total++; if (last_addr !== 2'd3) $display("FAIL to_next_addr: got %h want 3", last_addr); else passed++;
    endtask

    task automatic test_reset_mid;
        int c, base;
        bit saw_rsp;
        resp_mode = 1;
        push_cmd(1'b0, 2'd3, 8'h77, c);
        push_cmd(1'b0, 2'd1, 8'h55, c);
        push_cmd(1'b0, 2'd2, 8'h66, c);
        repeat (5) tick;
        total++; if (axi_addr !== 2'd3) $display("FAIL rm_wait_addr: got %h want 3", axi_addr); else passed++;
        base = n_wr + n_rd;
        rst = 1'b1;
        tick;
        total++; if (cmd_ready !== 1'b1) $display("FAIL rm_cmd_ready: got %b want 1", cmd_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rm_rsp_valid: got %b want 0", rsp_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else passed++;
        total++; if (axi_addr !== 2'd0) $display("FAIL rm_axi_addr: got %h want 0", axi_addr); else passed++;
        total++; if (axi_wdata !== 8'd0) $display("FAIL rm_axi_wdata: got %h want 00", axi_wdata); else passed++;
        rst = 1'b0;
        repeat (3) tick;
        force_req++;
        saw_rsp = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (rsp_valid) saw_rsp = 1;
        end
        total++; if (saw_rsp !== 1'b0) $display("FAIL rm_stale_done: got rsp_valid 1 want 0"); else passed++;
        total++; if (n_wr + n_rd - base !== 0) $display("FAIL rm_discard: got %0d issues want 0", n_wr + n_rd - base); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rm_busy_after: got %b want 0", busy); else passed++;
        resp_mode = 0;
    endtask

    task automatic test_simultaneous;
        int c, seen;
        bit acc_g, acc_now;
        logic rw, err;
        logic [7:0] rd;
        logic       exp_rw [7];
        logic [7:0] exp_rd [7];
        exp_rw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_rd = '{8'hA0, 8'h00, 8'h11, 8'h00, 8'h22, 8'hA0, 8'h00};
        rsp_ready = 1'b0; resp_mode = 1;
        push_cmd(1'b1, 2'd0, 8'h00, c);
        repeat (3) tick;
        push_cmd(1'b0, 2'd1, 8'h11, c);
        push_cmd(1'b1, 2'd1, 8'h00, c);
        push_cmd(1'b0, 2'd2, 8'h22, c);
        total++; if (cmd_ready !== 1'b1) $display("FAIL sim_three_ready: got %b want 1", cmd_ready); else passed++;
        // done is seen on the next edge, the pop lands one edge later, aligned with push E.
        force_req++;
        tick;
        tick;
        cmd_rw = 1'b1; cmd_addr = 2'd2; cmd_wdata = 8'h00; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b1) $display("FAIL sim_push_pop_ready: got %b want 1", cmd_ready); else passed++;
        push_cmd(1'b1, 2'd0, 8'h00, c);
        total++; if (cmd_ready !== 1'b0) $display("FAIL sim_full_ready: got %b want 0", cmd_ready); else passed++;
        // Full queue: the push is held off until the pop frees a slot, then refills it.
        resp_mode = 0; resp_lat = 3;
        force_req++;
        cmd_rw = 1'b0; cmd_addr = 2'd3; cmd_wdata = 8'h33; cmd_valid = 1'b1;
        acc_g = 0;
        for (int i = 0; i < 20; i++) begin
            acc_now = cmd_ready;
            tick;
            if (acc_now) begin acc_g = 1; break; end
        end
        cmd_valid = 1'b0;
        total++; if (acc_g !== 1'b1) $display("FAIL sim_refill_accept: got %b want 1", acc_g); else passed++;
        total++; if (cmd_ready !== 1'b0) $display("FAIL sim_refill_full: got %b want 0", cmd_ready); else passed++;
        for (int i = 0; i < 7; i++) begin
            get_rsp(rw, rd, err, seen);
            total++; if (rw !== exp_rw[i]) $display("FAIL sim_rsp%0d_rw: got %b want %b", i, rw, exp_rw[i]); else passed++;
            total++; if (rd !== exp_rd[i]) $display("FAIL sim_rsp%0d_rdata: got %h want %h", i, rd, exp_rd[i]); else passed++;
            total++; if (err !== 1'b0) $display("FAIL sim_rsp%0d_err: got %b want 0", i, err); else passed++;
        end
    endtask

    task automatic test_done_on_timeout;
        int c, st, seen;
        logic rw, err;
        logic [7:0] rd;
        resp_mode = 0; resp_lat = TIMEOUT; rsp_ready = 1'b0;
        push_cmd(1'b1, 2'd2, 8'h00, c);
        tick;
        st = start_cyc;
        get_rsp(rw, rd, err, seen);
        total++; if (seen - (st + 1) !== TIMEOUT) $display("FAIL dt_latency: got %0d cycles want %0d", seen - (st + 1), TIMEOUT); else passed++;
        total++; if (rw !== 1'b1) $display("FAIL dt_rsp_rw: got %b want 1", rw); else passed++;
        total++; if (rd !== 8'h22) $display("FAIL dt_rsp_rdata: got %h want 22", rd); else passed++;
        total++; if (err !== 1'b0) $display("FAIL dt_rsp_err: got %b want 0", err); else passed++;
        resp_lat = 3;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 2'd0; cmd_wdata = 8'd0;
        rsp_ready = 1'b0;
        test_reset;
        test_write_read;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        test_simultaneous;
        test_done_on_timeout;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
